// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types and constants for the RV32I fetch-stage PC sequencer
//
// Purpose : sequencer state encoding, default reset/trap vectors and the
//           instruction-alignment mask helper used by pc_sequencer.
// Ports   : none (package).
package rv32i_pkg;

    // Sequencer states: BOOT holds the PC during the boot hold-off, RUN fetches.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    // Low-order address bits that must be zero for an aligned instruction.
    // instr_bytes is a power of two, so the mask is simply instr_bytes-1.
    function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
        return 64'(instr_bytes) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/status bundle between branch-trap resolution and the PC sequencer
//
// Purpose : groups the fetch-control requests and the PC/fault outputs.
// Signals : Stall, Redirect_En, Redirect_Tgt, Trap_En  (requests into sequencer)
//           PC_Out, PC_Next_Seq, Fetch_Valid,
//           Misalign_Flt, Fault_Addr                   (status out of sequencer)
// Modports: master - requester side (drives requests, observes PC)
//           slave  - the sequencer itself
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            Stall;
    logic            Redirect_En;
    logic [XLEN-1:0] Redirect_Tgt;
    logic            Trap_En;

    logic [XLEN-1:0] PC_Out;
    logic [XLEN-1:0] PC_Next_Seq;
    logic            Fetch_Valid;
    logic            Misalign_Flt;
    logic [XLEN-1:0] Fault_Addr;

    modport master (
        output Stall,
        output Redirect_En,
        output Redirect_Tgt,
        output Trap_En,
        input  PC_Out,
        input  PC_Next_Seq,
        input  Fetch_Valid,
        input  Misalign_Flt,
        input  Fault_Addr
    );

    modport slave (
        input  Stall,
        input  Redirect_En,
        input  Redirect_Tgt,
        input  Trap_En,
        output PC_Out,
        output PC_Next_Seq,
        output Fetch_Valid,
        output Misalign_Flt,
        output Fault_Addr
    );
endinterface

// File: rtl/pc_redirect_buffer.sv
// rtl/pc_redirect_buffer.sv - one-entry holding register for a redirect that arrived during a stall
//
// Purpose : keeps the most recent stalled redirect target until it can be
//           applied or is discarded.
// Ports   : Clk, Reset (async, active-high)
//           load    in   capture tgt_in and set valid (overwrites older entry)
//           clear   in   drop the entry (load has priority)
//           tgt_in  in   target to capture
//           tgt     out  held target
//           vld     out  entry valid
module pc_redirect_buffer #(
    parameter int XLEN = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] tgt_in,
    output logic [XLEN-1:0] tgt,
    output logic            vld
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tgt <= '0;
            vld <= 1'b0;
        end else if (load) begin
            tgt <= tgt_in;
            vld <= 1'b1;
        end else if (clear) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - RV32I fetch-stage program-counter sequencer
//
// Purpose : holds the fetch PC and selects the next one each cycle:
//           sequential increment, branch/jump redirect, stall-deferred
//           redirect or trap entry, after a boot hold-off. Misaligned
//           redirect targets are diverted to the trap vector and reported.
// Ports   : Clk   in  clock, rising edge
//           Reset in  asynchronous, active-high reset
//           bus   pc_sequencer_if.slave
//                 Stall, Redirect_En, Redirect_Tgt, Trap_En  -> requests
//                 PC_Out, PC_Next_Seq, Fetch_Valid,
//                 Misalign_Flt, Fault_Addr                   <- status
module pc_sequencer
    import rv32i_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
    parameter int              INSTR_BYTES  = 4,
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    pc_sequencer_if.slave bus
);

    localparam int              CNT_W      = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_INIT = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(INSTR_BYTES));
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             flt_q, flt_d;
    logic [XLEN-1:0]  faddr_q, faddr_d;

    logic [XLEN-1:0]  pc_seq;
    logic             pend_load, pend_clear;
    logic [XLEN-1:0]  pend_tgt;
    logic             pend_vld;

    // Target chosen for immediate application this cycle (live or deferred).
    logic             apply_en;
    logic [XLEN-1:0]  apply_tgt;

    // Increment wraps naturally in XLEN bits; no wrap indication is wanted.
    assign pc_seq = pc_q + PC_STEP;

    pc_redirect_buffer #(
        .XLEN (XLEN)
    ) u_redirect_buffer (
        .Clk    (Clk),
        .Reset  (Reset),
        .load   (pend_load),
        .clear  (pend_clear),
        .tgt_in (bus.Redirect_Tgt),
        .tgt    (pend_tgt),
        .vld    (pend_vld)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= BOOT;
            boot_cnt_q <= BOOT_INIT;
            pc_q       <= RESET_VECTOR;
            flt_q      <= 1'b0;
            faddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            flt_q      <= flt_d;
            faddr_q    <= faddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        flt_d      = 1'b0;
        faddr_d    = faddr_q;
        pend_load  = 1'b0;
        pend_clear = 1'b0;
        apply_en   = 1'b0;
        apply_tgt  = '0;

        case (state_q)
            BOOT: begin
                // Inputs are ignored; PC stays at the reset vector.
                if (boot_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - CNT_W'(1);
                end
            end

            RUN: begin
                if (bus.Trap_En) begin
                    // Trap beats everything, including a same-cycle redirect,
                    // and also discards any deferred redirect.
                    pc_d       = TRAP_VECTOR;
                    pend_clear = 1'b1;
                end else if (bus.Redirect_En && !bus.Stall) begin
                    apply_en   = 1'b1;
                    apply_tgt  = bus.Redirect_Tgt;
                    pend_clear = 1'b1;
                end else if (bus.Redirect_En) begin
                    // Alignment is not judged here; it is judged when applied.
                    pend_load = 1'b1;
                end else if (!bus.Stall && pend_vld) begin
                    apply_en   = 1'b1;
                    apply_tgt  = pend_tgt;
                    pend_clear = 1'b1;
                end else if (!bus.Stall) begin
                    pc_d = pc_seq;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        if (apply_en) begin
            if ((apply_tgt & ALIGN_MASK) != '0) begin
                pc_d    = TRAP_VECTOR;
                flt_d   = 1'b1;
                faddr_d = apply_tgt;
            end else begin
                pc_d = apply_tgt;
            end
        end
    end

    assign bus.PC_Out       = pc_q;
    assign bus.PC_Next_Seq  = pc_seq;
    assign bus.Fetch_Valid  = (state_q == RUN);
    assign bus.Misalign_Flt = flt_q;
    assign bus.Fault_Addr   = faddr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] TV   = 32'h0000_0100;
    localparam int          IB   = 4;
    localparam int          BC   = 2;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    pc_sequencer_if #(.XLEN(XLEN)) bus ();

    pc_sequencer #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .INSTR_BYTES  (IB),
        .BOOT_CYCLES  (BC)
    ) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_run;
    int          m_boot_left;
    longint      m_pc;
    bit          m_pend;
    longint      m_ptgt;
    bit          m_flt;
    longint      m_faddr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run       = 0;
        m_boot_left = BC - 1;
        m_pc        = RV;
        m_pend      = 0;
        m_ptgt      = 0;
        m_flt       = 0;
        m_faddr     = 0;
    endtask

    task automatic model_apply(input longint t);
        if (t % IB != 0) begin
            m_pc    = TV;
            m_flt   = 1;
            m_faddr = t;
        end else begin
            m_pc = t;
        end
    endtask

    task automatic model_edge(input bit s, input bit r, input longint t, input bit tr);
        m_flt = 0;
        if (!m_run) begin
            if (m_boot_left == 0) m_run = 1;
            else m_boot_left--;
        end else if (tr) begin
            m_pc   = TV;
            m_pend = 0;
        end else if (r && !s) begin
            model_apply(t);
            m_pend = 0;
        end else if (r) begin
            m_pend = 1;
            m_ptgt = t;
        end else if (!s && m_pend) begin
            model_apply(m_ptgt);
            m_pend = 0;
        end else if (!s) begin
            m_pc = (m_pc + IB) % 64'h1_0000_0000;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"},    64'(bus.PC_Out),       64'(m_pc));
        check({tag, ".seq"},   64'(bus.PC_Next_Seq),  (m_pc + IB) % 64'h1_0000_0000);
        check({tag, ".valid"}, 64'(bus.Fetch_Valid),  64'(m_run));
        check({tag, ".flt"},   64'(bus.Misalign_Flt), 64'(m_flt));
        check({tag, ".faddr"}, 64'(bus.Fault_Addr),   64'(m_faddr));
    endtask

    // Called at a falling edge; drives inputs, lets one rising edge pass,
    // then compares just after it and returns at the next falling edge.
    task automatic step(input string tag, input bit s, input bit r,
                        input logic [31:0] t, input bit tr);
        bus.Stall        = s;
        bus.Redirect_En  = r;
        bus.Redirect_Tgt = t;
        bus.Trap_En      = tr;
        @(posedge Clk);
        #1;
        model_edge(s, r, longint'(t), tr);
        compare_all(tag);
        @(negedge Clk);
    endtask

    // Asserted mid-cycle (at a falling edge); checks the asynchronous effect.
    task automatic do_reset(input string tag);
        Reset = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        bus.Stall        = 1'b0;
        bus.Redirect_En  = 1'b0;
        bus.Redirect_Tgt = '0;
        bus.Trap_En      = 1'b0;

        @(negedge Clk);
        do_reset("reset");

        // 1: boot hold-off then sequential fetch
        step("boot0", 0, 0, 0, 0);
        check("t1_valid_boot", 64'(bus.Fetch_Valid), 0);
        step("boot1", 0, 0, 0, 0);
        check("t1_valid_run", 64'(bus.Fetch_Valid), 1);
        check("t1_pc0", 64'(bus.PC_Out), 64'h0);
        step("seq4", 0, 0, 0, 0);
        check("t1_pc4", 64'(bus.PC_Out), 64'h4);
        step("seq8", 0, 0, 0, 0);
        step("seqc", 0, 0, 0, 0);
        check("t1_pcc", 64'(bus.PC_Out), 64'hC);
        step("seq10", 0, 0, 0, 0);

        // 2: redirect
        step("redir40", 0, 1, 32'h40, 0);
        check("t2_pc40", 64'(bus.PC_Out), 64'h40);
        step("seq44", 0, 0, 0, 0);
        check("t2_pc44", 64'(bus.PC_Out), 64'h44);

        // 3: redirect deferred by stall
        step("redir20", 0, 1, 32'h20, 0);
        step("stall_redir", 1, 1, 32'h80, 0);
        check("t3_hold1", 64'(bus.PC_Out), 64'h20);
        step("stall_hold", 1, 0, 0, 0);
        check("t3_hold2", 64'(bus.PC_Out), 64'h20);
        step("stall_release", 0, 0, 0, 0);
        check("t3_pc80", 64'(bus.PC_Out), 64'h80);

        // 4: misaligned redirect, live and deferred
        step("mis42", 0, 1, 32'h42, 0);
        check("t4_pc", 64'(bus.PC_Out), 64'h100);
        check("t4_flt", 64'(bus.Misalign_Flt), 1);
        check("t4_faddr", 64'(bus.Fault_Addr), 64'h42);
        step("mis_after", 0, 0, 0, 0);
        check("t4_flt_drop", 64'(bus.Misalign_Flt), 0);
        step("mis_pend", 1, 1, 32'h43, 0);
        check("t4_pend_noflt", 64'(bus.Misalign_Flt), 0);
        step("mis_pend_apply", 0, 0, 0, 0);
        check("t4_pend_flt", 64'(bus.Misalign_Flt), 1);
        check("t4_pend_faddr", 64'(bus.Fault_Addr), 64'h43);

        // 5: trap priority and pending clear
        step("trap_redir", 0, 1, 32'h40, 1);
        check("t5_pc", 64'(bus.PC_Out), 64'h100);
        check("t5_noflt", 64'(bus.Misalign_Flt), 0);
        step("pend200", 1, 1, 32'h200, 0);
        step("trap_stall", 1, 0, 0, 1);
        check("t5_trap_stall", 64'(bus.PC_Out), 64'h100);
        step("after_trap", 0, 0, 0, 0);
        check("t5_pend_cleared", 64'(bus.PC_Out), 64'h104);

        // 6: wrap and mid-run reset
        step("to_top", 0, 1, 32'hFFFF_FFFC, 0);
        check("t6_seq_wrap", 64'(bus.PC_Next_Seq), 64'h0);
        step("wrap", 0, 0, 0, 0);
        check("t6_pc_wrap", 64'(bus.PC_Out), 64'h0);
        step("wrap_next", 0, 0, 0, 0);
        step("pend_before_rst", 1, 1, 32'h300, 0);
        do_reset("midreset");
        check("t6_rst_pc", 64'(bus.PC_Out), 64'h0);
        check("t6_rst_valid", 64'(bus.Fetch_Valid), 0);

        // Randomized traffic against the model, with occasional resets
        for (int i = 0; i < 400; i++) begin
            bit          s, r, tr;
            logic [31:0] t;
            s  = ($urandom_range(0, 99) < 30);
            r  = ($urandom_range(0, 99) < 25);
            tr = ($urandom_range(0, 99) < 5);
            t  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            if ($urandom_range(0, 99) == 0) do_reset("rnd_reset");
            else step("rnd", s, r, t, tr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
